ptr_walk_sequencer: RTL and testbench

//  Drives the control inputs (Wen/BusOut/RST/INC) of one row-pointer and one column-pointer

---
 rtl/ptr_walk_sequencer_pkg.sv | 6 +
 rtl/ptr_walk_sequencer_axis_cnt.sv | 24 ++
 rtl/ptr_walk_sequencer.sv | 170 +++++++++++++++++
 tb/tb_ptr_walk_sequencer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/ptr_walk_sequencer_pkg.sv
// ptr_walk_sequencer_pkg: shared FSM state encoding and default widths for the pointer walk sequencer
package ptr_walk_sequencer_pkg;
    localparam int PTR_W_DEF = 8;
    localparam int CNT_W_DEF = 8;
    typedef enum logic [2:0] {IDLE, CHECK, LOAD_R, LOAD_C, RUN, DONE} state_e;
endpackage

// File: rtl/ptr_walk_sequencer_axis_cnt.sv
// seq_axis_cnt: walk index counter for one axis, flags the terminal index cnt-1
//   clk_i/rstn_i  clock and synchronous active-low reset
//   clr_i         return index to 0 (wins over en_i)
//   en_i          advance index by one
//   cnt_i         number of positions on this axis
//   last_o        index is at cnt_i-1
module seq_axis_cnt import ptr_walk_sequencer_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic             last_o
);
    logic [CNT_W-1:0] idx_q, idx_d;
    assign idx_d  = clr_i ? '0 : en_i ? idx_q + 1'b1 : idx_q;
    assign last_o = idx_q == cnt_i - 1'b1;
    always_ff @(posedge clk_i) begin
        if (!rstn_i) idx_q <= '0;
        else         idx_q <= idx_d;
    end
endmodule

// File: rtl/ptr_walk_sequencer.sv
// ptr_walk_sequencer: walks a row x column tile in row-major order by driving two pointer registers
//   Clk/RSTn                  clock and synchronous active-low reset
//   start                     begin a walk (taken only when idle)
//   row_base/col_base         first row/column address
//   row_cnt/col_cnt           tile size
//   stall                     datapath not ready, hold current step
//   row_ptr/col_ptr           feedback from the pointer registers
//   bus_out                   shared load bus for both pointer registers
//   row_/col_ wen,rst,inc     pointer register controls
//   step_valid                pointers hold a valid step this cycle
//   busy/done/err             status; err pulses with done on a rejected walk
module ptr_walk_sequencer import ptr_walk_sequencer_pkg::*; #(
    parameter int PTR_W = PTR_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             RSTn,
    input  logic             start,
    input  logic [PTR_W-1:0] row_base,
    input  logic [PTR_W-1:0] col_base,
    input  logic [CNT_W-1:0] row_cnt,
    input  logic [CNT_W-1:0] col_cnt,
    input  logic             stall,
    input  logic [PTR_W-1:0] row_ptr,
    input  logic [PTR_W-1:0] col_ptr,
    output logic [PTR_W-1:0] bus_out,
    output logic             row_wen,
    output logic             row_rst,
    output logic             row_inc,
    output logic             col_wen,
    output logic             col_rst,
    output logic             col_inc,
    output logic             step_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);
    // one extra bit so base+cnt cannot wrap back into range
    localparam int SW = (PTR_W > CNT_W ? PTR_W : CNT_W) + 1;
    state_e           state_q, state_d;
    logic             rej_q, rej_d;
    logic [PTR_W-1:0] row_base_q, row_base_d, col_base_q, col_base_d;
    logic [CNT_W-1:0] row_cnt_q, row_cnt_d, col_cnt_q, col_cnt_d;
    logic [PTR_W-1:0] shadow_row_q, shadow_row_d, shadow_col_q, shadow_col_d;
    logic             shadow_valid_q, shadow_valid_d;
    logic             latch, shadow_upd, range_bad, in_run, acc, c_last, r_last;
    logic [SW-1:0]    row_end, col_end, lim;

    assign row_end   = SW'(row_base_q) + SW'(row_cnt_q);
    assign col_end   = SW'(col_base_q) + SW'(col_cnt_q);
    assign lim       = SW'(1) << PTR_W;
    assign range_bad = row_cnt_q == '0 || col_cnt_q == '0 || row_end > lim || col_end > lim;

    assign row_base_d     = latch ? row_base : row_base_q;
    assign col_base_d     = latch ? col_base : col_base_q;
    assign row_cnt_d      = latch ? row_cnt : row_cnt_q;
    assign col_cnt_d      = latch ? col_cnt : col_cnt_q;
    assign shadow_row_d   = shadow_upd ? row_base_q : shadow_row_q;
    assign shadow_col_d   = shadow_upd ? col_base_q : shadow_col_q;
    assign shadow_valid_d = shadow_upd | shadow_valid_q;

    assign in_run = state_q == RUN;
    assign acc    = in_run & ~stall;

    seq_axis_cnt #(.CNT_W(CNT_W)) u_c_idx (
        .clk_i(Clk), .rstn_i(RSTn), .clr_i(~in_run | (acc & c_last)), .en_i(acc),
        .cnt_i(col_cnt_q), .last_o(c_last)
    );
    seq_axis_cnt #(.CNT_W(CNT_W)) u_r_idx (
        .clk_i(Clk), .rstn_i(RSTn), .clr_i(~in_run), .en_i(acc & c_last),
        .cnt_i(row_cnt_q), .last_o(r_last)
    );

    // A pointer is loaded only when it reads 0 (fresh) or is known to already
    // sit on the requested base via the shadow; anything else is untrusted.
    always_comb begin
        state_d    = state_q;
        rej_d      = rej_q;
        latch      = 1'b0;
        shadow_upd = 1'b0;
        bus_out    = '0;
        row_wen    = 1'b0;
        row_rst    = 1'b0;
        row_inc    = 1'b0;
        col_wen    = 1'b0;
        col_rst    = 1'b0;
        col_inc    = 1'b0;
        step_valid = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        busy       = state_q != IDLE;
        case (state_q)
            IDLE: if (start) begin
                latch   = 1'b1;
                rej_d   = 1'b0;
                state_d = CHECK;
            end
            CHECK: begin
                rej_d   = range_bad;
                state_d = range_bad ? DONE : LOAD_R;
            end
            LOAD_R: if (row_ptr == '0) begin
                row_wen = 1'b1;
                bus_out = row_base_q;
                state_d = LOAD_C;
            end else if (shadow_valid_q && row_base_q == shadow_row_q) begin
                row_rst = 1'b1;
                state_d = LOAD_C;
            end else begin
                rej_d   = 1'b1;
                state_d = DONE;
            end
            LOAD_C: if (col_ptr == '0) begin
                col_wen    = 1'b1;
                bus_out    = col_base_q;
                shadow_upd = 1'b1;
                state_d    = RUN;
            end else if (shadow_valid_q && col_base_q == shadow_col_q) begin
                col_rst    = 1'b1;
                shadow_upd = 1'b1;
                state_d    = RUN;
            end else begin
                rej_d   = 1'b1;
                state_d = DONE;
            end
            RUN: begin
                step_valid = 1'b1;
                if (!stall) begin
                    if (!c_last) col_inc = 1'b1;
                    else if (!r_last) begin
                        col_rst = 1'b1;
                        row_inc = 1'b1;
                    end else state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                err     = rej_q;
                row_rst = ~rej_q;
                col_rst = ~rej_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!RSTn) begin
            state_q        <= IDLE;
            rej_q          <= 1'b0;
            row_base_q     <= '0;
            col_base_q     <= '0;
            row_cnt_q      <= '0;
            col_cnt_q      <= '0;
            shadow_row_q   <= '0;
            shadow_col_q   <= '0;
            shadow_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rej_q          <= rej_d;
            row_base_q     <= row_base_d;
            col_base_q     <= col_base_d;
            row_cnt_q      <= row_cnt_d;
            col_cnt_q      <= col_cnt_d;
            shadow_row_q   <= shadow_row_d;
            shadow_col_q   <= shadow_col_d;
            shadow_valid_q <= shadow_valid_d;
        end
    end
endmodule

// File: tb/tb_ptr_walk_sequencer.sv
// tb_ptr_walk_sequencer: scoreboard bench with behavioural row/column pointer registers
module tb_ptr_walk_sequencer;
    logic       Clk = 1'b0, RSTn = 1'b0, start = 1'b0, stall = 1'b0, fresh = 1'b0;
    logic [7:0] row_base = '0, col_base = '0, row_cnt = '0, col_cnt = '0;
    logic [7:0] row_ptr = '0, col_ptr = '0, row_pbase = '0, col_pbase = '0;
    logic [7:0] bus_out;
    logic       row_wen, row_rst, row_inc, col_wen, col_rst, col_inc;
    logic       step_valid, busy, done, err;
    int         n_vec = 0, n_bad = 0;
    logic [15:0] q[$];

    always #5 Clk = ~Clk;

    ptr_walk_sequencer dut (
        .Clk(Clk), .RSTn(RSTn), .start(start), .row_base(row_base), .col_base(col_base),
        .row_cnt(row_cnt), .col_cnt(col_cnt), .stall(stall), .row_ptr(row_ptr), .col_ptr(col_ptr),
        .bus_out(bus_out), .row_wen(row_wen), .row_rst(row_rst), .row_inc(row_inc),
        .col_wen(col_wen), .col_rst(col_rst), .col_inc(col_inc), .step_valid(step_valid),
        .busy(busy), .done(done), .err(err)
    );

    // pointer registers: Wen loads dout and base, RST returns to base, INC counts up
    always @(posedge Clk) begin
        if (fresh) begin
            row_ptr <= '0;
            col_ptr <= '0;
        end else begin
            if (row_wen) begin
                row_ptr   <= bus_out;
                row_pbase <= bus_out;
            end else if (row_rst) row_ptr <= row_pbase;
            else if (row_inc) row_ptr <= row_ptr + 8'd1;
            if (col_wen) begin
                col_ptr   <= bus_out;
                col_pbase <= bus_out;
            end else if (col_rst) col_ptr <= col_pbase;
            else if (col_inc) col_ptr <= col_ptr + 8'd1;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_walk(input int rb, input int cb, input int rc, input int cc, input bit rej,
                            input int rej_lat, input bit use_wen, input int st_step, input int st_len);
        int k, acc, stalled, wen_n, rsts, rinc_n, cinc_n, viol, lat, er;
        logic [7:0] pr0, pc0;
        pr0 = row_ptr;
        pc0 = col_ptr;
        if (!rej)
            for (int r = 0; r < rc; r++)
                for (int c = 0; c < cc; c++) q.push_back({8'(rb + r), 8'(cb + c)});
        row_base = 8'(rb);
        col_base = 8'(cb);
        row_cnt  = 8'(rc);
        col_cnt  = 8'(cc);
        start    = 1'b1;
        acc = 0; stalled = 0; wen_n = 0; rsts = 0; rinc_n = 0; cinc_n = 0; viol = 0; lat = -1; er = 0;
        for (k = 1; k <= 200 && lat < 0; k++) begin
            @(negedge Clk);
            start = 1'b0;
            stall = (st_step == acc + 1) && (stalled < st_len);
            #1;
            if (k == 1) check("busy", busy, 1);
            if (int'(row_wen) + int'(row_rst) + int'(row_inc) > 1) viol++;
            if (int'(col_wen) + int'(col_rst) + int'(col_inc) > 1) viol++;
            if (!row_wen && !col_wen && bus_out != 8'd0) viol++;
            wen_n  += int'(row_wen) + int'(col_wen);
            rsts   += int'(row_rst) + int'(col_rst);
            rinc_n += int'(row_inc);
            cinc_n += int'(col_inc);
            if (step_valid) begin
                if (q.size() == 0) check("step_extra", 1, 0);
                else begin
                    check("step_row", row_ptr, q[0][15:8]);
                    check("step_col", col_ptr, q[0][7:0]);
                end
                if (stall) stalled++;
                else begin
                    if (q.size() > 0) void'(q.pop_front());
                    acc++;
                end
            end
            if (done) begin
                lat = k;
                er  = int'(err);
            end
        end
        stall = 1'b0;
        check("done_lat", lat, rej ? rej_lat : 4 + rc * cc + st_len);
        check("err", er, int'(rej));
        check("accepts", acc, rej ? 0 : rc * cc);
        check("q_empty", q.size(), 0);
        q.delete();
        check("ctl_excl", viol, 0);
        check("wen_n", wen_n, use_wen ? 2 : 0);
        check("rst_n", rsts, rej ? 0 : (use_wen ? 0 : 2) + (rc - 1) + 2);
        check("row_inc", rinc_n, rej ? 0 : rc - 1);
        check("col_inc", cinc_n, rej ? 0 : rc * (cc - 1));
        @(negedge Clk);
        #1;
        check("park_row", row_ptr, rej ? int'(pr0) : rb);
        check("park_col", col_ptr, rej ? int'(pc0) : cb);
        check("idle", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge Clk);
        #1;
        check("rst_outs", {bus_out, row_wen, row_rst, row_inc, col_wen, col_rst, col_inc,
                           step_valid, busy, done, err}, 0);
        RSTn = 1'b1;
        run_walk(10, 20, 2, 3, 0, 0, 1, 0, 0);
        run_walk(10, 20, 2, 3, 0, 0, 0, 0, 0);
        run_walk(10, 20, 2, 3, 0, 0, 0, 4, 3);
        run_walk(30, 20, 2, 3, 1, 3, 0, 0, 0);
        run_walk(10, 20, 0, 3, 1, 2, 0, 0, 0);
        run_walk(10, 250, 2, 10, 1, 2, 0, 0, 0);
        run_walk(10, 20, 2, 0, 1, 2, 0, 0, 0);
        row_base = 8'd10;
        col_base = 8'd20;
        row_cnt  = 8'd2;
        col_cnt  = 8'd3;
        start    = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (5) @(negedge Clk);
        #1;
        check("mid_run", step_valid, 1);
        RSTn = 1'b0;
        @(negedge Clk);
        #1;
        check("rst_mid", {bus_out, row_wen, row_rst, row_inc, col_wen, col_rst, col_inc,
                          step_valid, busy, done, err}, 0);
        RSTn = 1'b1;
        run_walk(10, 20, 2, 3, 1, 3, 0, 0, 0);
        run_walk(10, 247, 1, 10, 1, 2, 0, 0, 0);
        fresh = 1'b1;
        @(negedge Clk);
        fresh = 1'b0;
        run_walk(10, 246, 1, 10, 0, 0, 1, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
